wavetable_player: RTL and testbench
===================================

# wavetable_player

Sequencer that walks the 2048×8 sample ROM (`memory`) at a programmable rate and step, and presents each fetched byte downstream on a valid/ready handshake. It sits directly upstream of the ROM, drives its `read_address`, and absorbs the ROM's one-cycle registered read latency. Typical use is as the source feeding a PWM/DAC or LED output stage.

## Interface
- `ADDR_WIDTH`, 11, ROM address width; must match ROM depth (2048).
- `DATA_WIDTH`, 8, ROM word width.
- `DIV_WIDTH`, 16, width of the inter-sample wait counter.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins playback from address 0 when idle.
- `stop`  in  1  one-cycle pulse; aborts playback, returns to idle.
- `step`  in  ADDR_WIDTH  address increment per sample; sampled on each advance.
- `period`  in  DIV_WIDTH  wait cycles before each fetch; sampled on WAIT entry.
- `read_address`  out  ADDR_WIDTH  registered address to ROM.
- `read_data`  in  DATA_WIDTH  ROM output, valid one cycle after address sampled.
- `sample_out`  out  DATA_WIDTH  held sample for downstream.
- `sample_valid`  out  1  sample_out holds an unconsumed sample.
- `sample_ready`  in  1  downstream accepts sample when high with sample_valid.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT, FETCH, CAPTURE, HOLD.
- IDLE: `start` (without `stop`) → read_address<=0, load counter with `period`; go WAIT, or FETCH if `period`==0. `start` in any other state is ignored.
- WAIT: counter decrements each cycle; on the cycle the counter reads 1, go FETCH. Lasts exactly `period` cycles.
- FETCH: read_address stable; ROM samples it at the closing edge. Go CAPTURE.
- CAPTURE: read_data is valid this cycle; at closing edge sample_out<=read_data, sample_valid<=1; go HOLD.
- HOLD: sample_valid high, sample_out and read_address stable until `sample_valid && sample_ready`. On that edge: sample_valid<=0, read_address<=read_address+step (mod 2^ADDR_WIDTH, carry discarded), reload counter with `period`; go WAIT (or FETCH if `period`==0).
- `stop` in any state: next edge → IDLE, sample_valid<=0; read_address and sample_out keep their values. `stop` and `start` together: stop wins.
- `step`==0: repeatedly replays the same address; legal.
- Wrap: address 2047 + step 1 → 0; 2040 + step 16 → 8.

## Timing
- Reset values: state IDLE, read_address 0, sample_out 0, sample_valid 0, busy 0, counter 0.
- Async reset mid-operation: all outputs return to reset values immediately; no sample completes.
- busy rises the edge after accepted `start`; falls the edge after `stop`.
- First sample_valid rises `period`+2 cycles after the `start` edge.
- With sample_ready tied high: one sample every `period`+3 cycles.
- sample_out never changes while sample_valid is high (AXI-style stability); sample_valid never drops without a handshake except by `stop`/reset.

## Structure
- Package `wavetable_pkg`: state enum (`IDLE, WAIT, FETCH, CAPTURE, HOLD`), default width localparams.
- Single module plus one natural sub-module: `tick_counter` (loadable down-counter with `load`, `value`, `done` at count 1); inline also acceptable.
- Bench instantiates `memory` with a ramp init file (mem[i] = i[7:0]) as the ROM model.

## Test plan
- Reset/idle: assert rst_n low mid-HOLD → all outputs 0 immediately; no sample_valid for 10 cycles after release without `start`.
- Basic ramp: period 0, step 1, ready high → samples 0x00,0x01,0x02… one every 3 cycles; first valid 2 cycles after start.
- Rate: period 5, step 3 → samples 0x00,0x03,0x06 spaced 8 cycles apart.
- Backpressure: ready low 7 cycles while valid → sample_out and read_address frozen, no sample lost or duplicated.
- Wrap: step 16, run past address 2047 → address sequence …2032, 0, 16 (data 0xF0, 0x00, 0x10).
- Stop: `stop` during WAIT and during HOLD → IDLE next edge, valid 0, busy 0; simultaneous start+stop in IDLE → stays IDLE.

Source files
------------

// File: rtl/wavetable_pkg.sv
// Shared types and default widths for the wavetable sample sequencer.
package wavetable_pkg;

  localparam int unsigned WtAddrWidth = 11;
  localparam int unsigned WtDataWidth = 8;
  localparam int unsigned WtDivWidth  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FETCH,
    CAPTURE,
    HOLD
  } state_e;

endpackage

// File: rtl/wavetable_player_tick_counter.sv
// Loadable down-counter; done flags the last cycle of a wait interval (value == 1).
module tick_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             en,
  output logic [Width-1:0] value,
  output logic             done
);

  logic [Width-1:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_value;
    end else if (en && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value = value_q;
  assign done  = (value_q == Width'(1));

endmodule

// File: rtl/wavetable_player.sv
// Walks the sample ROM at a programmable rate/step and hands each byte downstream
// on a valid/ready handshake, absorbing the ROM's one-cycle read latency.
module wavetable_player
  import wavetable_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WtAddrWidth,
  parameter int unsigned DATA_WIDTH = WtDataWidth,
  parameter int unsigned DIV_WIDTH  = WtDivWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] step,
  input  logic [DIV_WIDTH-1:0]  period,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy
);

  state_e               state_q;
  logic                 start_ok;
  logic                 handshake;
  logic                 cnt_load;
  logic                 cnt_done;
  logic [DIV_WIDTH-1:0] cnt_value;

  assign start_ok  = (state_q == IDLE) && start && !stop;
  assign handshake = (state_q == HOLD) && sample_valid && sample_ready && !stop;
  assign cnt_load  = start_ok || handshake;

  // Counter reloads on every WAIT entry so period is sampled there and nowhere else.
  tick_counter #(
    .Width (DIV_WIDTH)
  ) u_tick_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (period),
    .en         (state_q == WAIT),
    .value      (cnt_value),
    .done       (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      read_address <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (stop) begin
      // Address and sample are left as-is; only the handshake is withdrawn.
      state_q      <= IDLE;
      sample_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            read_address <= '0;
            state_q      <= (period == '0) ? FETCH : WAIT;
          end
        end
        WAIT: begin
          if (cnt_done) state_q <= FETCH;
        end
        FETCH: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          sample_out   <= read_data;
          sample_valid <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (handshake) begin
            sample_valid <= 1'b0;
            read_address <= read_address + step;
            state_q      <= (period == '0) ? FETCH : WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_wavetable_player.sv
// Randomized scoreboard bench for wavetable_player with a ramp-initialised ROM model.
module tb_wavetable_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] step = '0;
  logic [15:0] period = '0;
  logic [10:0] read_address;
  logic [7:0]  read_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        busy;

  wavetable_player dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .step         (step),
    .period       (period),
    .read_address (read_address),
    .read_data    (read_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ROM model: mem[i] = i[7:0], registered read.
  logic [7:0] rom [2048];
  initial for (int i = 0; i < 2048; i++) rom[i] = i[7:0];
  always @(posedge clk) read_data <= rom[read_address];

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_popped = 0;
  int   cyc = 0;
  int   cur_period = 0;
  bit   rate_chk = 0;
  int   ready_mode = 2;  // 0 random, 1 high, 2 low, 3 low for 7 valid cycles

  task automatic check(input bit ok, input string name, input int act, input int expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver.
  initial begin
    int vc = 0;
    forever begin
      @(posedge clk);
      #1;
      vc = sample_valid ? vc + 1 : 0;
      case (ready_mode)
        0: sample_ready = $urandom_range(1, 0) == 1;
        1: sample_ready = 1'b1;
        2: sample_ready = 1'b0;
        default: sample_ready = (vc > 7);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stability/rate.
  initial begin
    bit       prev_valid = 0;
    bit       prev_ready = 0;
    bit [7:0] prev_out = '0;
    bit [10:0] prev_addr = '0;
    int       last_acc = -1;
    exp_t     e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        last_acc = -1;
      end else begin
        if (prev_valid && !prev_ready && sample_valid) begin
          check(sample_out == prev_out, "hold_sample_stable", sample_out, prev_out);
          check(read_address == prev_addr, "hold_addr_stable", read_address, prev_addr);
        end
        if (!busy) last_acc = -1;
        if (sample_valid && sample_ready) begin
          if (exp_q.size() == 0) begin
            check(0, "unexpected_sample", sample_out, -1);
          end else begin
            e = exp_q.pop_front();
            check(sample_out == e.data[7:0], "sample_data", sample_out, e.data);
            check(read_address == e.addr[10:0], "sample_addr", read_address, e.addr);
            n_popped++;
          end
          if (rate_chk && last_acc >= 0)
            check(cyc - last_acc == cur_period + 3, "sample_rate", cyc - last_acc,
                  cur_period + 3);
          last_acc = cyc;
        end
        prev_valid = sample_valid;
        prev_ready = sample_ready;
        prev_out   = sample_out;
        prev_addr  = read_address;
      end
    end
  end

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check(busy == 1'b0, "stop_busy", busy, 0);
    check(sample_valid == 1'b0, "stop_valid", sample_valid, 0);
  endtask

  task automatic run_playback(input int p, input int s, input int n, input int mode);
    int lat;
    int guard;
    exp_t e;
    period     = 16'(p);
    step       = 11'(s);
    cur_period = p;
    ready_mode = mode;
    rate_chk   = (mode == 1);
    n_popped   = 0;
    for (int k = 0; k < n; k++) begin
      e.addr = (k * s) % 2048;
      e.data = e.addr % 256;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check(busy == 1'b1, "busy_rise", busy, 1);
    lat = 0;
    while (!sample_valid && lat < p + 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(lat == p + 2, "first_valid_latency", lat, p + 2);
    guard = 0;
    while (n_popped < n && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(n_popped == n, "samples_drained", n_popped, n);
    pulse_stop();
    check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    rate_chk = 0;
  endtask

  initial begin
    int lat;
    // Reset state.
    #12;
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(sample_valid == 1'b0, "reset_valid", sample_valid, 0);
    check(read_address == 11'd0, "reset_addr", read_address, 0);
    check(sample_out == 8'd0, "reset_sample", sample_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_playback(0, 1, 8, 1);    // basic ramp
    run_playback(5, 3, 4, 1);    // rate
    run_playback(0, 1, 4, 3);    // backpressure, ready low 7 cycles
    run_playback(0, 16, 131, 1); // wrap past 2047
    run_playback(2, 2047, 5, 1); // step wraps every advance
    for (int r = 0; r < 4; r++)
      run_playback($urandom_range(6, 0), $urandom_range(2047, 0), $urandom_range(10, 5), 0);

    // Stop during WAIT.
    period = 16'd5;
    step = 11'd1;
    ready_mode = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    pulse_stop();

    // Stop during HOLD: address and sample held, only valid withdrawn.
    period = 16'd0;
    ready_mode = 2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!sample_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(sample_valid == 1'b1, "hold_reached", sample_valid, 1);
    pulse_stop();
    check(read_address == 11'd0, "stop_addr_kept", read_address, 0);

    // Simultaneous start and stop in IDLE.
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check(busy == 1'b0, "start_stop_idle", busy, 0);
      @(posedge clk);
      #1;
    end

    // Async reset mid-HOLD.
    period = 16'd1;
    step = 11'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!sample_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
    check(sample_valid == 1'b1, "pre_reset_hold", sample_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check(sample_valid == 1'b0, "async_rst_valid", sample_valid, 0);
    check(busy == 1'b0, "async_rst_busy", busy, 0);
    check(read_address == 11'd0, "async_rst_addr", read_address, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check(sample_valid == 1'b0, "post_reset_quiet", sample_valid, 0);
    end

    // Playback still works after reset.
    run_playback(3, 7, 5, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
